// File: rtl/fetch_unit_pkg.sv
// Shared widths and FSM encodings for the instruction fetch stage.
package fetch_unit_pkg;

    localparam int ADDR_W_DEF  = 32;
    localparam int INSTR_W_DEF = 32;

    typedef enum logic [1:0] {
        FS_BOOT  = 2'd0,
        FS_RUN   = 2'd1,
        FS_DRAIN = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Small registered FIFO with synchronous clear; DEPTH must be a power of two so pointers wrap naturally.
module fetch_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    input  logic                       clear,
    output logic [WIDTH-1:0]           head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: credit-limited in-order imem reads, buffered {pc, instr} handed to decode.
// state    | meaning
// FS_BOOT  | first cycle after reset, no requests issued
// FS_RUN   | normal fetch, every response is kept
// FS_DRAIN | discarding responses to reads issued before the last flush
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int INSTR_W = INSTR_W_DEF,
    parameter int DEPTH   = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [ADDR_W-1:0]  pc_in,
    output logic               pc_enable,
    input  logic               flush,
    output logic               imem_req_valid,
    output logic [ADDR_W-1:0]  imem_req_addr,
    input  logic               imem_req_ready,
    input  logic               imem_resp_valid,
    input  logic [INSTR_W-1:0] imem_resp_data,
    output logic               dec_valid,
    output logic [INSTR_W-1:0] dec_instr,
    output logic [ADDR_W-1:0]  dec_pc,
    input  logic               dec_ready
);

    localparam int          CW      = $clog2(DEPTH+1);
    localparam logic [CW:0] CREDITS = (CW+1)'(DEPTH);

    fetch_state_e              state;
    fetch_state_e              state_nxt;
    logic [CW-1:0]             inflight;
    logic [CW-1:0]             drop_cnt;
    logic [CW-1:0]             drop_cnt_nxt;
    logic [CW-1:0]             pc_count;
    logic [CW-1:0]             out_count;
    logic                      pc_full;
    logic                      pc_empty;
    logic                      out_full;
    logic                      out_empty;
    logic [ADDR_W-1:0]         pc_head;
    logic [ADDR_W+INSTR_W-1:0] out_head;
    logic [CW:0]               credit_used;
    logic                      issue;
    logic                      resp;
    logic                      resp_keep;
    logic                      dec_pop;
    logic                      unused_status;

    assign credit_used    = {1'b0, inflight} + {1'b0, out_count};
    assign imem_req_valid = (state != FS_BOOT) & ~flush & (credit_used < CREDITS);
    assign imem_req_addr  = pc_in;
    assign issue          = imem_req_valid & imem_req_ready;
    assign pc_enable      = issue | flush;

    // A response with nothing outstanding is ignored rather than corrupting the counters.
    assign resp      = imem_resp_valid & (inflight != '0);
    assign resp_keep = resp & (drop_cnt == '0) & ~flush;

    assign dec_valid = ~out_empty & ~flush;
    assign dec_pop   = dec_valid & dec_ready;
    assign dec_pc    = out_head[ADDR_W+INSTR_W-1:INSTR_W];
    assign dec_instr = out_head[INSTR_W-1:0];

    assign unused_status = ^{pc_count, pc_full, pc_empty, out_full};

    // Flush recomputes the drop count from what is still outstanding, never accumulates.
    always_comb begin
        drop_cnt_nxt = drop_cnt;
        if (flush) begin
            drop_cnt_nxt = inflight - CW'(resp);
        end else if (resp && (drop_cnt != '0)) begin
            drop_cnt_nxt = drop_cnt - CW'(1);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            FS_BOOT:  state_nxt = FS_RUN;
            FS_RUN:   if (flush && (drop_cnt_nxt != '0)) state_nxt = FS_DRAIN;
            FS_DRAIN: if (drop_cnt_nxt == '0) state_nxt = FS_RUN;
            default:  state_nxt = FS_BOOT;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= FS_BOOT;
            inflight <= '0;
            drop_cnt <= '0;
        end else begin
            state    <= state_nxt;
            drop_cnt <= drop_cnt_nxt;
            inflight <= inflight + CW'(issue) - CW'(resp);
        end
    end

    fetch_fifo #(.WIDTH(ADDR_W), .DEPTH(DEPTH)) pc_q (
        .clk       (clk),
        .reset     (reset),
        .push      (issue),
        .push_data (pc_in),
        .pop       (resp_keep),
        .clear     (flush),
        .head      (pc_head),
        .full      (pc_full),
        .empty     (pc_empty),
        .count     (pc_count)
    );

    fetch_fifo #(.WIDTH(ADDR_W+INSTR_W), .DEPTH(DEPTH)) out_q (
        .clk       (clk),
        .reset     (reset),
        .push      (resp_keep),
        .push_data ({pc_head, imem_resp_data}),
        .pop       (dec_pop),
        .clear     (flush),
        .head      (out_head),
        .full      (out_full),
        .empty     (out_empty),
        .count     (out_count)
    );

    resp_without_request: assert property (@(posedge clk) disable iff (reset)
        !(imem_resp_valid && (inflight == '0)));

endmodule

// File: tb/tb_fetch_unit.sv
// Directed and randomised checks of fetch_unit against a PC/memory model and a decode scoreboard.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    localparam int AW    = 32;
    localparam int IW    = 32;
    localparam int DEPTH = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [AW-1:0] pc_in;
    logic          pc_enable;
    logic          flush;
    logic          imem_req_valid;
    logic [AW-1:0] imem_req_addr;
    logic          imem_req_ready;
    logic          imem_resp_valid;
    logic [IW-1:0] imem_resp_data;
    logic          dec_valid;
    logic [IW-1:0] dec_instr;
    logic [AW-1:0] dec_pc;
    logic          dec_ready;

    always #5 clk = ~clk;

    fetch_unit #(.ADDR_W(AW), .INSTR_W(IW), .DEPTH(DEPTH)) dut (
        .clk             (clk),
        .reset           (reset),
        .pc_in           (pc_in),
        .pc_enable       (pc_enable),
        .flush           (flush),
        .imem_req_valid  (imem_req_valid),
        .imem_req_addr   (imem_req_addr),
        .imem_req_ready  (imem_req_ready),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .dec_valid       (dec_valid),
        .dec_instr       (dec_instr),
        .dec_pc          (dec_pc),
        .dec_ready       (dec_ready)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    mreq_t       mq[$];
    logic [31:0] exp_q[$];
    logic [31:0] got_q[$];
    logic [31:0] flush_target;
    int          cyc = 0;
    int          lat_min = 1;
    int          lat_max = 1;
    int          n_checks = 0;
    int          n_fail = 0;

    function automatic logic [31:0] mdata(input logic [31:0] a);
        return {a[15:0] ^ 16'hC0DE, a[15:0]};
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock: sample mid-cycle, then advance the PC, memory and scoreboard models.
    task automatic tick();
        logic        iss, pop, flu, en, rv;
        logic [31:0] a, dpc, din, e;
        @(negedge clk);
        iss = imem_req_valid & imem_req_ready;
        a   = imem_req_addr;
        pop = dec_valid & dec_ready;
        dpc = dec_pc;
        din = dec_instr;
        flu = flush;
        en  = pc_enable;
        rv  = imem_resp_valid;
        check_eq("pc_enable_rule", 64'(en), 64'(iss | flu));
        @(posedge clk);
        #1;
        cyc++;
        if (rv && mq.size() > 0) void'(mq.pop_front());
        if (pop) begin
            got_q.push_back(dpc);
            if (exp_q.size() == 0) begin
                check_eq("sb_dec_with_nothing_pending", 64'(exp_q.size()), 64'd1);
            end else begin
                e = exp_q.pop_front();
                check_eq("sb_pc", 64'(dpc), 64'(e));
                check_eq("sb_instr", 64'(din), 64'(mdata(e)));
            end
        end
        if (flu) exp_q.delete();
        if (iss) begin
            exp_q.push_back(a);
            mq.push_back('{a, cyc + int'($urandom_range(lat_max, lat_min)) - 1});
        end
        if (en) pc_in = flu ? flush_target : pc_in + 32'd1;
        flush = 1'b0;
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = mdata(mq[0].addr);
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = '0;
        end
        #1;
    endtask

    task automatic do_reset(input logic [31:0] start);
        reset           = 1'b1;
        flush           = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        mq.delete();
        exp_q.delete();
        got_q.delete();
        pc_in = start;
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
    endtask

    task automatic run_until_got(input int n, input int budget, input string tag);
        int k = 0;
        while (got_q.size() < n && k < budget) begin
            tick();
            k++;
        end
        check_eq(tag, 64'(got_q.size()), 64'(n));
    endtask

    initial begin
        pc_in          = '0;
        flush          = 1'b0;
        flush_target   = '0;
        imem_req_ready = 1'b1;
        imem_resp_valid = 1'b0;
        imem_resp_data = '0;
        dec_ready      = 1'b1;

        // Reset state
        #1 reset = 1'b1;
        #2;
        check_eq("rst_req_valid", 64'(imem_req_valid), 64'd0);
        check_eq("rst_pc_enable", 64'(pc_enable), 64'd0);
        check_eq("rst_dec_valid", 64'(dec_valid), 64'd0);
        check_eq("rst_dec_pc", 64'(dec_pc), 64'd0);
        check_eq("rst_dec_instr", 64'(dec_instr), 64'd0);
        check_eq("rst_state", 64'(dut.state), 64'(FS_BOOT));
        check_eq("rst_inflight", 64'(dut.inflight), 64'd0);
        check_eq("rst_drop_cnt", 64'(dut.drop_cnt), 64'd0);

        // 1: streaming fetch, 1-cycle memory, decode always ready
        do_reset(32'd0);
        check_eq("t1_boot_req_valid", 64'(imem_req_valid), 64'd0);
        tick();
        check_eq("t1_run_state", 64'(dut.state), 64'(FS_RUN));
        check_eq("t1_a_req_valid", 64'(imem_req_valid), 64'd1);
        check_eq("t1_a_req_addr", 64'(imem_req_addr), 64'd0);
        tick();
        check_eq("t1_b_no_bypass", 64'(dec_valid), 64'd0);
        check_eq("t1_b_req_addr", 64'(imem_req_addr), 64'd1);
        check_eq("t1_b_req_valid", 64'(imem_req_valid), 64'd1);
        tick();
        check_eq("t1_c_dec_valid", 64'(dec_valid), 64'd1);
        check_eq("t1_c_dec_pc", 64'(dec_pc), 64'd0);
        check_eq("t1_c_dec_instr", 64'(dec_instr), 64'(mdata(32'd0)));
        check_eq("t1_c_credit_full", 64'(imem_req_valid), 64'd0);
        run_until_got(4, 40, "t1_four_decodes");
        for (int i = 0; i < 4; i++) check_eq($sformatf("t1_order_%0d", i), 64'(got_q[i]), 64'(i));

        // 2: decode backpressure holds the PC
        do_reset(32'd0);
        run_until_got(2, 40, "t2_first_two");
        dec_ready = 1'b0;
        repeat (8) tick();
        check_eq("t2_stall_req_valid", 64'(imem_req_valid), 64'd0);
        check_eq("t2_stall_pc_enable", 64'(pc_enable), 64'd0);
        check_eq("t2_stall_dec_valid", 64'(dec_valid), 64'd1);
        check_eq("t2_stall_dec_pc", 64'(dec_pc), 64'd2);
        check_eq("t2_stall_dec_instr", 64'(dec_instr), 64'(mdata(32'd2)));
        check_eq("t2_stall_held_addr", 64'(imem_req_addr), 64'd4);
        dec_ready = 1'b1;
        run_until_got(6, 40, "t2_resume");
        for (int i = 0; i < 6; i++) check_eq($sformatf("t2_order_%0d", i), 64'(got_q[i]), 64'(i));

        // 3: flush with two reads outstanding
        lat_min = 4;
        lat_max = 4;
        do_reset(32'd4);
        tick();
        check_eq("t3_first_addr", 64'(imem_req_addr), 64'd4);
        tick();
        check_eq("t3_second_addr", 64'(imem_req_addr), 64'd5);
        tick();
        check_eq("t3_inflight", 64'(dut.inflight), 64'd2);
        flush        = 1'b1;
        flush_target = 32'h40;
        #1;
        check_eq("t3_flush_pc_enable", 64'(pc_enable), 64'd1);
        check_eq("t3_flush_req_valid", 64'(imem_req_valid), 64'd0);
        tick();
        check_eq("t3_drop_cnt", 64'(dut.drop_cnt), 64'd2);
        check_eq("t3_state_drain", 64'(dut.state), 64'(FS_DRAIN));
        check_eq("t3_redirect_addr", 64'(imem_req_addr), 64'h40);
        run_until_got(1, 60, "t3_dec_after_flush");
        check_eq("t3_first_dec_pc", 64'(got_q[0]), 64'h40);
        check_eq("t3_drop_done", 64'(dut.drop_cnt), 64'd0);
        check_eq("t3_state_run", 64'(dut.state), 64'(FS_RUN));

        // 4: flush in the same cycle as a response
        lat_min = 1;
        lat_max = 1;
        do_reset(32'h10);
        tick();
        tick();
        tick();
        flush        = 1'b1;
        flush_target = 32'h80;
        #1;
        check_eq("t4_flush_dec_valid", 64'(dec_valid), 64'd0);
        check_eq("t4_flush_pc_enable", 64'(pc_enable), 64'd1);
        check_eq("t4_flush_req_valid", 64'(imem_req_valid), 64'd0);
        tick();
        check_eq("t4_drop_cnt", 64'(dut.drop_cnt), 64'd0);
        check_eq("t4_inflight", 64'(dut.inflight), 64'd0);
        check_eq("t4_state", 64'(dut.state), 64'(FS_RUN));
        run_until_got(1, 40, "t4_dec_after_flush");
        check_eq("t4_first_dec_pc", 64'(got_q[0]), 64'h80);

        // 5: async reset mid-stream
        lat_min = 4;
        lat_max = 4;
        do_reset(32'd0);
        tick();
        tick();
        tick();
        check_eq("t5_inflight_pre", 64'(dut.inflight), 64'd2);
        #1;
        reset           = 1'b1;
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        mq.delete();
        exp_q.delete();
        got_q.delete();
        pc_in = '0;
        #1;
        check_eq("t5_req_valid", 64'(imem_req_valid), 64'd0);
        check_eq("t5_pc_enable", 64'(pc_enable), 64'd0);
        check_eq("t5_dec_valid", 64'(dec_valid), 64'd0);
        check_eq("t5_dec_pc", 64'(dec_pc), 64'd0);
        check_eq("t5_inflight", 64'(dut.inflight), 64'd0);
        check_eq("t5_state", 64'(dut.state), 64'(FS_BOOT));
        tick();
        reset = 1'b0;
        #1;
        check_eq("t5_boot_state", 64'(dut.state), 64'(FS_BOOT));
        check_eq("t5_boot_req_valid", 64'(imem_req_valid), 64'd0);
        tick();
        check_eq("t5_first_req_valid", 64'(imem_req_valid), 64'd1);
        check_eq("t5_first_req_addr", 64'(imem_req_addr), 64'd0);

        // 6: random latency, readiness and flushes against the scoreboard
        lat_min = 1;
        lat_max = 4;
        do_reset(32'd0);
        tick();
        for (int i = 0; i < 3000; i++) begin
            imem_req_ready = ($urandom_range(3, 0) != 0);
            dec_ready      = ($urandom_range(2, 0) != 0);
            if ($urandom_range(24, 0) == 0) begin
                flush        = 1'b1;
                flush_target = 32'($urandom_range(16'hFFFF, 0)) << 4;
            end
            #1;
            tick();
        end
        check_eq("t6_progress", 64'(got_q.size() >= 200), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
